// File: rtl/cc_hit_miss_dispatcher.sv
// cc_hit_miss_dispatcher: turns tag-compare results into in-order hit-flag
// writes, hit-line writes and 8-beat WRAP AR requests for misses. Lookups are
// throttled by the FIFO almost-full flags and by the number of outstanding
// miss bursts.
// Optional feature macro: CC_DISPATCH_PERF_EN (adds hit/miss event counters).
module cc_hit_miss_dispatcher #(
  parameter int ADDR_WIDTH           = 32,
  parameter int MAX_OUTSTANDING_MISS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic                  lookup_hit_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic [511:0]          lookup_data_i,
  input  logic                  hit_flag_fifo_afull_i,
  output logic                  hit_flag_fifo_wren_o,
  output logic                  hit_flag_fifo_wdata_o,
  input  logic                  hit_data_fifo_afull_i,
  output logic                  hit_data_fifo_wren_o,
  output logic [517:0]          hit_data_fifo_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_rready_i,
  input  logic                  mem_rlast_i
`ifdef CC_DISPATCH_PERF_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    AR_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING_MISS);

  state_e                  state_q, state_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [3:0]              outstanding_q, outstanding_d;
  logic                    flag_wren_q, flag_wren_d;
  logic                    flag_wdata_q, flag_wdata_d;
  logic                    data_wren_q, data_wren_d;
  logic [517:0]            data_wdata_q, data_wdata_d;
  logic                    accept_s;
  logic                    miss_inc_s;
  logic                    burst_done_s;

  // Ready: idle, flag FIFO has room, and the resource the lookup type needs.
  always_comb begin
    lookup_ready_o = 1'b0;
    if ((state_q == IDLE) && !hit_flag_fifo_afull_i) begin
      if (lookup_hit_i) begin
        lookup_ready_o = !hit_data_fifo_afull_i;
      end else begin
        lookup_ready_o = (outstanding_q < MAX_OUT);
      end
    end else begin
      lookup_ready_o = 1'b0;
    end
  end

  assign accept_s     = lookup_valid_i && lookup_ready_o;
  assign miss_inc_s   = accept_s && !lookup_hit_i;
  assign burst_done_s = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  // Next-state and AR channel: a miss parks the FSM until AR is taken.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    case (state_q)
      IDLE: begin
        if (miss_inc_s) begin
          state_d   = AR_WAIT;
          arvalid_d = 1'b1;
          araddr_d  = {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
        end else begin
          arvalid_d = 1'b0;
        end
      end
      AR_WAIT: begin
        if (mem_arready_i) begin
          state_d   = IDLE;
          arvalid_d = 1'b0;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Flag/data write pulses and outstanding-miss bookkeeping.
  always_comb begin
    flag_wren_d  = accept_s;
    flag_wdata_d = accept_s && lookup_hit_i;
    data_wren_d  = accept_s && lookup_hit_i;
    data_wdata_d = data_wdata_q;
    if (accept_s && lookup_hit_i) begin
      data_wdata_d = {lookup_addr_i[5:0], lookup_data_i};
    end else begin
      data_wdata_d = data_wdata_q;
    end
    outstanding_d = outstanding_q;
    if (miss_inc_s && burst_done_s) begin
      outstanding_d = outstanding_q;
    end else if (miss_inc_s) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (burst_done_s && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      outstanding_q <= 4'd0;
      flag_wren_q   <= 1'b0;
      flag_wdata_q  <= 1'b0;
      data_wren_q   <= 1'b0;
      data_wdata_q  <= 518'd0;
    end else begin
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      outstanding_q <= outstanding_d;
      flag_wren_q   <= flag_wren_d;
      flag_wdata_q  <= flag_wdata_d;
      data_wren_q   <= data_wren_d;
      data_wdata_q  <= data_wdata_d;
    end
  end

  assign hit_flag_fifo_wren_o  = flag_wren_q;
  assign hit_flag_fifo_wdata_o = flag_wdata_q;
  assign hit_data_fifo_wren_o  = data_wren_q;
  assign hit_data_fifo_wdata_o = data_wdata_q;
  assign mem_araddr_o          = araddr_q;
  assign mem_arvalid_o         = arvalid_q;
  assign mem_arlen_o           = 4'd7;
  assign mem_arsize_o          = 3'b011;
  assign mem_arburst_o         = 2'b10;

`ifdef CC_DISPATCH_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Accepted hit/miss event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (accept_s && lookup_hit_i) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_inc_s) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cc_hit_miss_dispatcher.sv
// Scoreboard bench for cc_hit_miss_dispatcher: expected flag writes, hit-line
// writes and AR addresses are queued when a lookup is accepted and compared
// when the DUT produces them.
module tb_cc_hit_miss_dispatcher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lookup_valid_i = 1'b0;
  logic         lookup_ready_o;
  logic         lookup_hit_i = 1'b0;
  logic [31:0]  lookup_addr_i = 32'd0;
  logic [511:0] lookup_data_i = 512'd0;
  logic         hit_flag_fifo_afull_i = 1'b0;
  logic         hit_flag_fifo_wren_o;
  logic         hit_flag_fifo_wdata_o;
  logic         hit_data_fifo_afull_i = 1'b0;
  logic         hit_data_fifo_wren_o;
  logic [517:0] hit_data_fifo_wdata_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic         mem_rready_i = 1'b0;
  logic         mem_rlast_i = 1'b0;
`ifdef CC_DISPATCH_PERF_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  cc_hit_miss_dispatcher #(.ADDR_WIDTH(32), .MAX_OUTSTANDING_MISS(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .lookup_valid_i        (lookup_valid_i),
    .lookup_ready_o        (lookup_ready_o),
    .lookup_hit_i          (lookup_hit_i),
    .lookup_addr_i         (lookup_addr_i),
    .lookup_data_i         (lookup_data_i),
    .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
    .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
    .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
    .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
    .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
    .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
    .mem_araddr_o          (mem_araddr_o),
    .mem_arlen_o           (mem_arlen_o),
    .mem_arsize_o          (mem_arsize_o),
    .mem_arburst_o         (mem_arburst_o),
    .mem_arvalid_o         (mem_arvalid_o),
    .mem_arready_i         (mem_arready_i),
    .mem_rvalid_i          (mem_rvalid_i),
    .mem_rready_i          (mem_rready_i),
    .mem_rlast_i           (mem_rlast_i)
`ifdef CC_DISPATCH_PERF_EN
    ,
    .hit_cnt_o             (hit_cnt_o),
    .miss_cnt_o            (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int data_seen  = 0;
  int ar_seen    = 0;
  int hits_model   = 0;
  int misses_model = 0;

  logic         flag_q[$];
  logic [517:0] data_q[$];
  logic [31:0]  ar_q[$];

  task automatic check_value(input string tag, input logic [517:0] obs, input logic [517:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled 2 time units after the falling edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (hit_flag_fifo_wren_o) begin
        if (flag_q.size() == 0) check_value("flag_unexpected", hit_flag_fifo_wren_o, 1'b0);
        else check_value("flag_wdata", hit_flag_fifo_wdata_o, flag_q.pop_front());
      end
      if (hit_data_fifo_wren_o) begin
        data_seen++;
        if (data_q.size() == 0) check_value("data_unexpected", hit_data_fifo_wren_o, 1'b0);
        else check_value("data_wdata", hit_data_fifo_wdata_o, data_q.pop_front());
      end
      if (mem_arvalid_o && mem_arready_i) begin
        ar_seen++;
        check_value("arlen", mem_arlen_o, 4'd7);
        check_value("arsize", mem_arsize_o, 3'b011);
        check_value("arburst", mem_arburst_o, 2'b10);
        if (ar_q.size() == 0) check_value("ar_unexpected", mem_arvalid_o, 1'b0);
        else check_value("araddr", mem_araddr_o, ar_q.pop_front());
      end
    end
  end

  // Presents one lookup starting at a falling edge; returns at a falling edge.
  task automatic do_lookup(input logic hit, input logic [31:0] addr, input logic [511:0] data,
                           input int budget, output logic accepted);
    accepted       = 1'b0;
    lookup_valid_i = 1'b1;
    lookup_hit_i   = hit;
    lookup_addr_i  = addr;
    lookup_data_i  = data;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (lookup_ready_o) begin
        accepted = 1'b1;
        flag_q.push_back(hit);
        if (hit) begin
          data_q.push_back({addr[5:0], data});
          hits_model++;
        end else begin
          ar_q.push_back({addr[31:3], 3'b000});
          misses_model++;
        end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    lookup_valid_i = 1'b0;
  endtask

  task automatic pulse_rlast(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rvalid_i = 1'b1;
      mem_rready_i = 1'b1;
      mem_rlast_i  = 1'b1;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rready_i = 1'b0;
      mem_rlast_i  = 1'b0;
    end
  endtask

  // Four misses pass, the fifth stalls until one burst completes.
  task automatic miss_limit(input string tag);
    logic acc;
    mem_arready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_lookup(1'b0, 32'h0000_2000 + 32'(i * 64), 512'd0, 8, acc);
      check_value({tag, "_acc"}, acc, 1'b1);
    end
    do_lookup(1'b0, 32'h0000_3000, 512'd0, 6, acc);
    check_value({tag, "_stall"}, acc, 1'b0);
    pulse_rlast(1);
    do_lookup(1'b0, 32'h0000_3000, 512'd0, 6, acc);
    check_value({tag, "_release"}, acc, 1'b1);
    @(negedge clk);
    @(negedge clk);
    mem_arready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         acc;
    logic [511:0] pat;
    logic [517:0] exp_line;
    int           d0, a0;

    for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);

    // Reset state, AR constants tied during reset.
    #3;
    check_value("rst_arvalid", mem_arvalid_o, 1'b0);
    check_value("rst_flag_wren", hit_flag_fifo_wren_o, 1'b0);
    check_value("rst_data_wren", hit_data_fifo_wren_o, 1'b0);
    check_value("rst_arlen", mem_arlen_o, 4'd7);
    check_value("rst_arburst", mem_arburst_o, 2'b10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single hit: flag and data written the next cycle, no AR.
    do_lookup(1'b1, 32'h0000_1238, pat, 4, acc);
    check_value("hit_acc", acc, 1'b1);
    #1;
    exp_line = {6'h38, pat};
    check_value("hit_flag_lat", hit_flag_fifo_wren_o, 1'b1);
    check_value("hit_data_lat", hit_data_fifo_wren_o, 1'b1);
    check_value("hit_data_val", hit_data_fifo_wdata_o, exp_line);
    check_value("hit_no_ar", mem_arvalid_o, 1'b0);
    @(negedge clk);
    check_value("hit_pulse_end", hit_flag_fifo_wren_o, 1'b0);

    // Single miss with arready held low for 3 cycles.
    do_lookup(1'b0, 32'h0000_1238, 512'd0, 4, acc);
    check_value("miss_acc", acc, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_value("miss_arvalid_hold", mem_arvalid_o, 1'b1);
      check_value("miss_araddr_hold", mem_araddr_o, 32'h0000_1238);
      check_value("miss_ready_low", lookup_ready_o, 1'b0);
      @(negedge clk);
    end
    mem_arready_i = 1'b1;
    @(negedge clk);
    mem_arready_i = 1'b0;
    #1;
    check_value("miss_arvalid_drop", mem_arvalid_o, 1'b0);
    @(negedge clk);

    // Data FIFO almost full blocks hits only.
    hit_data_fifo_afull_i = 1'b1;
    lookup_hit_i = 1'b1;
    #1;
    check_value("afull_hit_ready", lookup_ready_o, 1'b0);
    lookup_hit_i = 1'b0;
    #1;
    check_value("afull_miss_ready", lookup_ready_o, 1'b1);
    hit_flag_fifo_afull_i = 1'b1;
    #1;
    check_value("flag_afull_ready", lookup_ready_o, 1'b0);
    hit_flag_fifo_afull_i = 1'b0;
    hit_data_fifo_afull_i = 1'b0;
    @(negedge clk);

    // Mixed H, M, H, H, M.
    mem_arready_i = 1'b1;
    d0 = data_seen;
    a0 = ar_seen;
    do_lookup(1'b1, 32'h0000_4001, ~pat, 8, acc);
    do_lookup(1'b0, 32'h0000_4047, 512'd0, 8, acc);
    do_lookup(1'b1, 32'h0000_4082, pat ^ {16{32'h1234_5678}}, 8, acc);
    do_lookup(1'b1, 32'h0000_40FF, {16{32'hDEAD_BEEF}}, 8, acc);
    do_lookup(1'b0, 32'h0000_41C5, 512'd0, 8, acc);
    repeat (3) @(negedge clk);
    mem_arready_i = 1'b0;
    check_value("mixed_data_cnt", 32'(data_seen - d0), 32'd3);
    check_value("mixed_ar_cnt", 32'(ar_seen - a0), 32'd2);

    // Drain 3 outstanding bursts plus two extra that must not underflow.
    pulse_rlast(5);
    miss_limit("limit");

    // Reset while in AR_WAIT with two outstanding misses.
    pulse_rlast(4);
    mem_arready_i = 1'b1;
    do_lookup(1'b0, 32'h0000_5000, 512'd0, 6, acc);
    @(negedge clk);
    mem_arready_i = 1'b0;
    do_lookup(1'b0, 32'h0000_5040, 512'd0, 6, acc);
    @(negedge clk);
    check_value("pre_rst_arvalid", mem_arvalid_o, 1'b1);
    rst_n = 1'b0;
    ar_q.delete();
    hits_model   = 0;
    misses_model = 0;
    #1;
    check_value("async_rst_arvalid", mem_arvalid_o, 1'b0);
`ifdef CC_DISPATCH_PERF_EN
    check_value("rst_hit_cnt", hit_cnt_o, 32'd0);
    check_value("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    miss_limit("post_rst");

`ifdef CC_DISPATCH_PERF_EN
    check_value("hit_cnt", hit_cnt_o, 32'(hits_model));
    check_value("miss_cnt", miss_cnt_o, 32'(misses_model));
`endif
    repeat (3) @(negedge clk);
    check_value("flag_q_empty", 32'(flag_q.size()), 32'd0);
    check_value("data_q_empty", 32'(data_q.size()), 32'd0);
    check_value("ar_q_empty", 32'(ar_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
